// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, ALU/memory/exception
// codes, instruction field positions and the link register index.
package isa_pkg;

    localparam int OP_LSB   = 26;
    localparam int OP_W     = 6;
    localparam int RA_LSB   = 21;
    localparam int RB_LSB   = 16;
    localparam int RC_LSB   = 11;
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = 16;
    localparam int LINK_REG = 31;

    // Even opcodes below 0x10 are R-form, odd ones the matching I-form.
    typedef enum logic [5:0] {
        OP_ANDR  = 6'h00, OP_ANDI  = 6'h01,
        OP_ORR   = 6'h02, OP_ORI   = 6'h03,
        OP_XORR  = 6'h04, OP_XORI  = 6'h05,
        OP_ADDSR = 6'h06, OP_ADDSI = 6'h07,
        OP_ADDUR = 6'h08, OP_ADDUI = 6'h09,
        OP_SUBSR = 6'h0A, OP_SUBSI = 6'h0B,
        OP_SUBUR = 6'h0C, OP_SUBUI = 6'h0D,
        OP_SHRLR = 6'h0E, OP_SHRLI = 6'h0F,
        OP_BE    = 6'h10, OP_BNE   = 6'h11,
        OP_BSR   = 6'h12, OP_JMP   = 6'h13,
        OP_LDW   = 6'h14, OP_STW   = 6'h15
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_ADDS = 4'd4,
        ALU_ADDU = 4'd5,
        ALU_SUBS = 4'd6,
        ALU_SUBU = 4'd7,
        ALU_SHRL = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        MEM_NOP = 2'd0,
        MEM_LDW = 2'd1,
        MEM_STW = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        EXP_NONE  = 2'd0,
        EXP_UNDEF = 2'd1
    } exp_code_t;

    // ALU function of an R/I pair, selected by opcode bits [3:1].
    function automatic alu_op_t alu_of(input logic [2:0] fn);
        case (fn)
            3'd0:    return ALU_AND;
            3'd1:    return ALU_OR;
            3'd2:    return ALU_XOR;
            3'd3:    return ALU_ADDS;
            3'd4:    return ALU_ADDU;
            3'd5:    return ALU_SUBS;
            3'd6:    return ALU_SUBU;
            default: return ALU_SHRL;
        endcase
    endfunction

endpackage

// File: rtl/decoder.sv
// Combinational decode, operand forwarding and branch evaluation for id_stage.
// Forwarding from EX/MEM is compiled in only when ID_FWD_EN is defined.
module decoder
    import isa_pkg::*;
#(
    parameter int GPR_ADDR_W = 5
) (
    input  logic [29:0]           if_pc,
    input  logic [31:0]           if_insn,
    input  logic                  if_en,
    input  logic [31:0]           gpr_rd_data_0,
    input  logic [31:0]           gpr_rd_data_1,
    input  logic                  ex_en,
    input  logic                  ex_gpr_we_,
    input  logic [GPR_ADDR_W-1:0] ex_dst_addr,
    input  logic [31:0]           ex_fwd_data,
    input  logic                  mem_en,
    input  logic                  mem_gpr_we_,
    input  logic [GPR_ADDR_W-1:0] mem_dst_addr,
    input  logic [31:0]           mem_fwd_data,
    output logic [GPR_ADDR_W-1:0] ra_addr,
    output logic [GPR_ADDR_W-1:0] rb_addr,
    output logic                  ra_used,
    output logic                  rb_used,
    output logic                  br_taken,
    output logic [29:0]           br_addr,
    output alu_op_t               alu_op,
    output logic [31:0]           alu_in_0,
    output logic [31:0]           alu_in_1,
    output mem_op_t               mem_op,
    output logic [31:0]           mem_wr_data,
    output logic [GPR_ADDR_W-1:0] dst_addr,
    output logic                  gpr_we_,
    output exp_code_t             exp_code
);

    logic [OP_W-1:0]       op;
    logic [GPR_ADDR_W-1:0] rc_addr;
    logic [IMM_W-1:0]      imm;
    logic [31:0]           simm, zimm, imm_ext;
    logic [31:0]           ra_data, rb_data;
    logic [29:0]           rel_target;
    logic                  br_hit;

    assign op      = if_insn[OP_LSB +: OP_W];
    assign ra_addr = if_insn[RA_LSB +: GPR_ADDR_W];
    assign rb_addr = if_insn[RB_LSB +: GPR_ADDR_W];
    assign rc_addr = if_insn[RC_LSB +: GPR_ADDR_W];
    assign imm     = if_insn[IMM_LSB +: IMM_W];
    assign simm    = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    assign zimm    = {{(32-IMM_W){1'b0}}, imm};
    assign imm_ext = (op inside {OP_ANDI, OP_ORI, OP_XORI}) ? zimm : simm;

`ifdef ID_FWD_EN
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

    assign ex_hit_a  = ex_en  & ~ex_gpr_we_  & (ex_dst_addr  == ra_addr);
    assign ex_hit_b  = ex_en  & ~ex_gpr_we_  & (ex_dst_addr  == rb_addr);
    assign mem_hit_a = mem_en & ~mem_gpr_we_ & (mem_dst_addr == ra_addr);
    assign mem_hit_b = mem_en & ~mem_gpr_we_ & (mem_dst_addr == rb_addr);

    // EX holds the younger result, so it takes priority over MEM.
    assign ra_data = ex_hit_a ? ex_fwd_data : mem_hit_a ? mem_fwd_data : gpr_rd_data_0;
    assign rb_data = ex_hit_b ? ex_fwd_data : mem_hit_b ? mem_fwd_data : gpr_rd_data_1;
`else
    logic unused_fwd;

    assign unused_fwd = ^{ex_en, ex_gpr_we_, ex_dst_addr, ex_fwd_data,
                          mem_en, mem_gpr_we_, mem_dst_addr, mem_fwd_data};
    assign ra_data    = gpr_rd_data_0;
    assign rb_data    = gpr_rd_data_1;
`endif

    assign rel_target = if_pc + 30'd1 + simm[29:0];

    always_comb begin
        ra_used     = 1'b0;
        rb_used     = 1'b0;
        br_hit      = 1'b0;
        br_addr     = rel_target;
        alu_op      = ALU_NOP;
        alu_in_0    = '0;
        alu_in_1    = '0;
        mem_op      = MEM_NOP;
        mem_wr_data = '0;
        dst_addr    = '0;
        gpr_we_     = 1'b1;
        exp_code    = EXP_NONE;
        if (op[5:4] == 2'b00) begin
            alu_op   = alu_of(op[3:1]);
            alu_in_0 = ra_data;
            ra_used  = 1'b1;
            gpr_we_  = 1'b0;
            if (op[0]) begin
                alu_in_1 = imm_ext;
                dst_addr = rb_addr;
            end else begin
                alu_in_1 = rb_data;
                dst_addr = rc_addr;
                rb_used  = 1'b1;
            end
        end else begin
            case (op)
                OP_BE, OP_BNE: begin
                    ra_used = 1'b1;
                    rb_used = 1'b1;
                    br_hit  = (ra_data == rb_data) ^ (op == OP_BNE);
                end
                OP_BSR: begin
                    br_hit   = 1'b1;
                    alu_op   = ALU_ADDU;
                    alu_in_0 = {if_pc + 30'd1, 2'b00};
                    dst_addr = GPR_ADDR_W'(LINK_REG);
                    gpr_we_  = 1'b0;
                end
                OP_JMP: begin
                    ra_used = 1'b1;
                    br_hit  = 1'b1;
                    br_addr = ra_data[31:2];
                end
                OP_LDW: begin
                    ra_used  = 1'b1;
                    alu_op   = ALU_ADDU;
                    alu_in_0 = ra_data;
                    alu_in_1 = simm;
                    mem_op   = MEM_LDW;
                    dst_addr = rb_addr;
                    gpr_we_  = 1'b0;
                end
                OP_STW: begin
                    ra_used     = 1'b1;
                    rb_used     = 1'b1;
                    alu_op      = ALU_ADDU;
                    alu_in_0    = ra_data;
                    alu_in_1    = simm;
                    mem_op      = MEM_STW;
                    mem_wr_data = rb_data;
                end
                default: exp_code = EXP_UNDEF;
            endcase
        end
    end

    assign br_taken = br_hit & if_en;

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: ID/EX pipeline register and load/RAW hazard detection.
// Build option: ID_FWD_EN enables EX/MEM operand forwarding.
module id_stage
    import isa_pkg::*;
#(
    parameter int GPR_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [29:0]           if_pc,
    input  logic [31:0]           if_insn,
    input  logic                  if_en,
    output logic [GPR_ADDR_W-1:0] gpr_rd_addr_0,
    output logic [GPR_ADDR_W-1:0] gpr_rd_addr_1,
    input  logic [31:0]           gpr_rd_data_0,
    input  logic [31:0]           gpr_rd_data_1,
    input  logic                  ex_en,
    input  logic                  ex_gpr_we_,
    input  logic [GPR_ADDR_W-1:0] ex_dst_addr,
    input  logic [31:0]           ex_fwd_data,
    input  logic                  mem_en,
    input  logic                  mem_gpr_we_,
    input  logic [GPR_ADDR_W-1:0] mem_dst_addr,
    input  logic [31:0]           mem_fwd_data,
    output logic                  br_taken,
    output logic [29:0]           br_addr,
    output logic                  ld_hazard,
    output logic                  id_en,
    output logic [29:0]           id_pc,
    output logic [3:0]            id_alu_op,
    output logic [31:0]           id_alu_in_0,
    output logic [31:0]           id_alu_in_1,
    output logic [1:0]            id_mem_op,
    output logic [31:0]           id_mem_wr_data,
    output logic [GPR_ADDR_W-1:0] id_dst_addr,
    output logic                  id_gpr_we_,
    output logic [1:0]            id_exp_code
);

    typedef struct packed {
        logic                  en;
        logic [29:0]           pc;
        logic [3:0]            alu_op;
        logic [31:0]           alu_in_0;
        logic [31:0]           alu_in_1;
        logic [1:0]            mem_op;
        logic [31:0]           mem_wr_data;
        logic [GPR_ADDR_W-1:0] dst_addr;
        logic                  gpr_we_;
        logic [1:0]            exp_code;
    } idex_t;

    // Reset and bubble share one encoding: all zero, write disabled.
    localparam idex_t BUBBLE = '{gpr_we_: 1'b1, default: '0};

    logic [GPR_ADDR_W-1:0] ra_addr, rb_addr, dec_dst_addr;
    logic                  ra_used, rb_used, dec_br_taken, dec_gpr_we_;
    logic [29:0]           dec_br_addr;
    alu_op_t               dec_alu_op;
    logic [31:0]           dec_alu_in_0, dec_alu_in_1, dec_mem_wr_data;
    mem_op_t               dec_mem_op;
    exp_code_t             dec_exp_code;
    idex_t                 dec, idex_q;
    logic                  load_use;

    decoder #(.GPR_ADDR_W(GPR_ADDR_W)) u_decoder (
        .if_pc         (if_pc),
        .if_insn       (if_insn),
        .if_en         (if_en),
        .gpr_rd_data_0 (gpr_rd_data_0),
        .gpr_rd_data_1 (gpr_rd_data_1),
        .ex_en         (ex_en),
        .ex_gpr_we_    (ex_gpr_we_),
        .ex_dst_addr   (ex_dst_addr),
        .ex_fwd_data   (ex_fwd_data),
        .mem_en        (mem_en),
        .mem_gpr_we_   (mem_gpr_we_),
        .mem_dst_addr  (mem_dst_addr),
        .mem_fwd_data  (mem_fwd_data),
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .ra_used       (ra_used),
        .rb_used       (rb_used),
        .br_taken      (dec_br_taken),
        .br_addr       (dec_br_addr),
        .alu_op        (dec_alu_op),
        .alu_in_0      (dec_alu_in_0),
        .alu_in_1      (dec_alu_in_1),
        .mem_op        (dec_mem_op),
        .mem_wr_data   (dec_mem_wr_data),
        .dst_addr      (dec_dst_addr),
        .gpr_we_       (dec_gpr_we_),
        .exp_code      (dec_exp_code)
    );

    assign gpr_rd_addr_0 = ra_addr;
    assign gpr_rd_addr_1 = rb_addr;

    assign load_use = id_en & (id_mem_op == MEM_LDW) & ~id_gpr_we_ & if_en &
                      ((ra_used & (id_dst_addr == ra_addr)) |
                       (rb_used & (id_dst_addr == rb_addr)));

`ifdef ID_FWD_EN
    assign ld_hazard = load_use;
`else
    logic ex_raw, mem_raw;

    // Without forwarding, any pending write to a used source must stall.
    assign ex_raw  = ex_en & ~ex_gpr_we_ &
                     ((ra_used & (ex_dst_addr == ra_addr)) |
                      (rb_used & (ex_dst_addr == rb_addr)));
    assign mem_raw = mem_en & ~mem_gpr_we_ &
                     ((ra_used & (mem_dst_addr == ra_addr)) |
                      (rb_used & (mem_dst_addr == rb_addr)));
    assign ld_hazard = load_use | (if_en & (ex_raw | mem_raw));
`endif

    // Never redirect on operands that the hazard says are stale.
    assign br_taken = dec_br_taken & ~ld_hazard;
    assign br_addr  = dec_br_addr;

    assign dec = '{
        en:          1'b1,
        pc:          if_pc,
        alu_op:      dec_alu_op,
        alu_in_0:    dec_alu_in_0,
        alu_in_1:    dec_alu_in_1,
        mem_op:      dec_mem_op,
        mem_wr_data: dec_mem_wr_data,
        dst_addr:    dec_dst_addr,
        gpr_we_:     dec_gpr_we_,
        exp_code:    dec_exp_code
    };

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= BUBBLE;
        end else if (!stall) begin
            if (flush || !if_en) idex_q <= BUBBLE;
            else                 idex_q <= dec;
        end
    end

    assign id_en          = idex_q.en;
    assign id_pc          = idex_q.pc;
    assign id_alu_op      = idex_q.alu_op;
    assign id_alu_in_0    = idex_q.alu_in_0;
    assign id_alu_in_1    = idex_q.alu_in_1;
    assign id_mem_op      = idex_q.mem_op;
    assign id_mem_wr_data = idex_q.mem_wr_data;
    assign id_dst_addr    = idex_q.dst_addr;
    assign id_gpr_we_     = idex_q.gpr_we_;
    assign id_exp_code    = idex_q.exp_code;

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against a behavioural decode model.
module tb_id_stage;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, if_en;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
    logic        ex_en, ex_gpr_we_, mem_en, mem_gpr_we_;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic        br_taken, ld_hazard, id_en, id_gpr_we_;
    logic [29:0] br_addr, id_pc;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
    logic [1:0]  id_mem_op, id_exp_code;
    logic [4:0]  id_dst_addr;

    logic [31:0] rf [32];
    assign gpr_rd_data_0 = rf[gpr_rd_addr_0];
    assign gpr_rd_data_1 = rf[gpr_rd_addr_1];

    always #5 clk = ~clk;

    id_stage #(.GPR_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
        .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .ex_en(ex_en), .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr), .ex_fwd_data(ex_fwd_data),
        .mem_en(mem_en), .mem_gpr_we_(mem_gpr_we_), .mem_dst_addr(mem_dst_addr), .mem_fwd_data(mem_fwd_data),
        .br_taken(br_taken), .br_addr(br_addr), .ld_hazard(ld_hazard),
        .id_en(id_en), .id_pc(id_pc), .id_alu_op(id_alu_op),
        .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
        .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
        .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code)
    );

    typedef struct packed {
        logic        en;
        logic [29:0] pc;
        logic [3:0]  alu_op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [1:0]  mem_op;
        logic [31:0] wd;
        logic [4:0]  dst;
        logic        we_;
        logic [1:0]  exc;
    } rec_t;

    rec_t        st;          // model of the ID/EX register
    rec_t        m_dec;       // model decode of the current IF/ID slot
    logic        m_taken, m_haz;
    logic [29:0] m_tgt;
    logic [3:0]  alu_tab [8];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    function automatic rec_t bubble();
        rec_t b = '0;
        b.we_ = 1'b1;
        return b;
    endfunction

    // Operand value as the decode stage should see it.
    function automatic logic [31:0] opnd(input logic [4:0] r);
        logic [31:0] v;
        v = rf[r];
`ifdef ID_FWD_EN
        if (mem_en && !mem_gpr_we_ && mem_dst_addr == r) v = mem_fwd_data;
        if (ex_en && !ex_gpr_we_ && ex_dst_addr == r) v = ex_fwd_data;
`endif
        return v;
    endfunction

    function automatic logic pend(input logic e, input logic w, input logic [4:0] d, input logic [4:0] r);
        return e && !w && d == r;
    endfunction

    task automatic model_comb();
        int          op;
        logic [4:0]  ra, rb, rc;
        logic [31:0] va, vb, simm, zimm;
        logic        ua, ub, haz;
        op   = int'(if_insn[31:26]);
        ra   = if_insn[25:21];
        rb   = if_insn[20:16];
        rc   = if_insn[15:11];
        va   = opnd(ra);
        vb   = opnd(rb);
        simm = {{16{if_insn[15]}}, if_insn[15:0]};
        zimm = {16'h0, if_insn[15:0]};
        m_dec = bubble();
        m_dec.en = 1'b1;
        m_dec.pc = if_pc;
        m_taken = 1'b0;
        m_tgt = if_pc + 30'd1 + simm[29:0];
        ua = 1'b0;
        ub = 1'b0;
        if (op < 16) begin
            m_dec.alu_op = alu_tab[op / 2];
            m_dec.in0 = va;
            m_dec.we_ = 1'b0;
            ua = 1'b1;
            if (op % 2 == 1) begin
                m_dec.in1 = (op < 6) ? zimm : simm;
                m_dec.dst = rb;
            end else begin
                m_dec.in1 = vb;
                m_dec.dst = rc;
                ub = 1'b1;
            end
        end else if (op == 16 || op == 17) begin
            ua = 1'b1;
            ub = 1'b1;
            m_taken = (va == vb) == (op == 16);
        end else if (op == 18) begin
            m_taken = 1'b1;
            m_dec.alu_op = ALU_ADDU;
            m_dec.in0 = {if_pc + 30'd1, 2'b00};
            m_dec.in1 = 32'd0;
            m_dec.dst = 5'd31;
            m_dec.we_ = 1'b0;
        end else if (op == 19) begin
            ua = 1'b1;
            m_taken = 1'b1;
            m_tgt = va[31:2];
        end else if (op == 20 || op == 21) begin
            ua = 1'b1;
            m_dec.alu_op = ALU_ADDU;
            m_dec.in0 = va + 32'd0;
            m_dec.in1 = simm;
            if (op == 20) begin
                m_dec.mem_op = MEM_LDW;
                m_dec.dst = rb;
                m_dec.we_ = 1'b0;
            end else begin
                ub = 1'b1;
                m_dec.mem_op = MEM_STW;
                m_dec.wd = vb;
            end
        end else begin
            m_dec.exc = EXP_UNDEF;
        end
        haz = st.en && st.mem_op == MEM_LDW && !st.we_ &&
              ((ua && st.dst == ra) || (ub && st.dst == rb));
`ifndef ID_FWD_EN
        haz = haz || (ua && (pend(ex_en, ex_gpr_we_, ex_dst_addr, ra) || pend(mem_en, mem_gpr_we_, mem_dst_addr, ra)))
                  || (ub && (pend(ex_en, ex_gpr_we_, ex_dst_addr, rb) || pend(mem_en, mem_gpr_we_, mem_dst_addr, rb)));
`endif
        m_haz = if_en && haz;
        m_taken = if_en && m_taken && !m_haz;
    endtask

    task automatic check_regs();
        chk("id_en", id_en, st.en);
        chk("id_gpr_we_", id_gpr_we_, st.we_);
        chk("id_mem_op", id_mem_op, st.mem_op);
        chk("id_exp_code", id_exp_code, st.exc);
        chk("id_pc", id_pc, st.pc);
        if (!st.en) begin
            chk("bubble_alu_op", id_alu_op, 0);
            chk("bubble_in0", id_alu_in_0, 0);
            chk("bubble_in1", id_alu_in_1, 0);
            chk("bubble_wd", id_mem_wr_data, 0);
            chk("bubble_dst", id_dst_addr, 0);
        end else begin
            if (!st.we_ || st.mem_op != MEM_NOP) begin
                chk("id_alu_op", id_alu_op, st.alu_op);
                chk("id_alu_in_0", id_alu_in_0, st.in0);
                chk("id_alu_in_1", id_alu_in_1, st.in1);
            end
            if (!st.we_) chk("id_dst_addr", id_dst_addr, st.dst);
            if (st.mem_op == MEM_STW) chk("id_mem_wr_data", id_mem_wr_data, st.wd);
        end
    endtask

    task automatic apply(input logic [31:0] insn, input logic [29:0] pc,
                         input logic en, input logic s, input logic f);
        @(negedge clk);
        if_insn = insn;
        if_pc   = pc;
        if_en   = en;
        stall   = s;
        flush   = f;
        #1;
        model_comb();
        chk("gpr_rd_addr_0", gpr_rd_addr_0, insn[25:21]);
        chk("gpr_rd_addr_1", gpr_rd_addr_1, insn[20:16]);
        chk("ld_hazard", ld_hazard, m_haz);
        chk("br_taken", br_taken, m_taken);
        if (m_taken) chk("br_addr", br_addr, m_tgt);
    endtask

    task automatic clock_in();
        rec_t nxt;
        nxt = st;
        if (!stall) nxt = (flush || !if_en) ? bubble() : m_dec;
        @(posedge clk);
        st = nxt;
        #1;
        check_regs();
    endtask

    localparam logic [31:0] I_ADDUR_R4 = {6'h08, 5'd4, 5'd1, 5'd6, 11'd0};

    initial begin
        logic [31:0] r, insn;
        logic [5:0]  op;
        int          k;
        alu_tab = '{ALU_AND, ALU_OR, ALU_XOR, ALU_ADDS, ALU_ADDU, ALU_SUBS, ALU_SUBU, ALU_SHRL};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'd0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; if_en = 1'b0;
        if_pc = '0; if_insn = '0;
        ex_en = 1'b0; ex_gpr_we_ = 1'b1; ex_dst_addr = '0; ex_fwd_data = '0;
        mem_en = 1'b0; mem_gpr_we_ = 1'b1; mem_dst_addr = '0; mem_fwd_data = '0;
        st = bubble();
        #12;
        check_regs();
        @(negedge clk);
        reset = 1'b1;

        // ADDUI r1 <- r0 + 0x8000: immediate is sign-extended
        apply({6'h09, 5'd0, 5'd1, 16'h8000}, 30'h40, 1'b1, 1'b0, 1'b0);
        clock_in();
        chk("addui_in1", id_alu_in_1, 32'hFFFF8000);
        chk("addui_dst", id_dst_addr, 5'd1);
        chk("addui_we_", id_gpr_we_, 1'b0);
        chk("addui_en", id_en, 1'b1);

        // BE taken backwards, then not taken
        rf[2] = 32'd5; rf[3] = 32'd5;
        apply({6'h10, 5'd2, 5'd3, 16'hFFFE}, 30'h100, 1'b1, 1'b0, 1'b0);
        chk("be_taken", br_taken, 1'b1);
        chk("be_addr", br_addr, 30'hFF);
        clock_in();
        rf[3] = 32'd6;
        apply({6'h10, 5'd2, 5'd3, 16'hFFFE}, 30'h100, 1'b1, 1'b0, 1'b0);
        chk("be_not_taken", br_taken, 1'b0);
        clock_in();

        // EX and MEM both writing r3, ORR reads r3
        ex_en = 1'b1; ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd3; ex_fwd_data = 32'hAA;
        mem_en = 1'b1; mem_gpr_we_ = 1'b0; mem_dst_addr = 5'd3; mem_fwd_data = 32'hBB;
        apply({6'h02, 5'd3, 5'd0, 5'd5, 11'd0}, 30'h104, 1'b1, 1'b0, 1'b0);
`ifndef ID_FWD_EN
        chk("raw_hazard", ld_hazard, 1'b1);
`endif
        clock_in();
`ifdef ID_FWD_EN
        chk("fwd_ex_wins", id_alu_in_0, 32'hAA);
`endif
        ex_en = 1'b0; mem_en = 1'b0;

        // LDW r4 then ADDUR using r4
        apply({6'h14, 5'd0, 5'd4, 16'h0010}, 30'h108, 1'b1, 1'b0, 1'b0);
        clock_in();
        apply(I_ADDUR_R4, 30'h109, 1'b1, 1'b1, 1'b0);
        chk("load_use", ld_hazard, 1'b1);
        clock_in();
        apply(I_ADDUR_R4, 30'h109, 1'b0, 1'b1, 1'b0);
        chk("load_use_no_if_en", ld_hazard, 1'b0);
        clock_in();

        // stall wins over flush, then flush alone
        apply(I_ADDUR_R4, 30'h109, 1'b1, 1'b1, 1'b1);
        clock_in();
        chk("stall_flush_en", id_en, 1'b1);
        chk("stall_flush_mem", id_mem_op, MEM_LDW);
        apply(I_ADDUR_R4, 30'h109, 1'b1, 1'b0, 1'b1);
        clock_in();
        chk("flush_en", id_en, 1'b0);
        chk("flush_we_", id_gpr_we_, 1'b1);
        chk("flush_mem", id_mem_op, MEM_NOP);

        // Undefined opcode
        apply({6'h3F, 26'h0}, 30'h10A, 1'b1, 1'b0, 1'b0);
        clock_in();
        chk("undef_exp", id_exp_code, EXP_UNDEF);
        chk("undef_we_", id_gpr_we_, 1'b1);

        // Asynchronous reset in the middle of a cycle
        apply({6'h09, 5'd0, 5'd7, 16'h1234}, 30'h10B, 1'b1, 1'b0, 1'b0);
        clock_in();
        #2 reset = 1'b0;
        #1;
        st = bubble();
        chk("async_rst_en", id_en, 1'b0);
        check_regs();
        reset = 1'b1;

        // Random traffic, small register indices to provoke hazards and matches
        for (int n = 0; n < 500; n++) begin
            k = int'($urandom_range(0, 24));
            if (k < 22)       op = 6'(k);
            else if (k == 22) op = 6'h3F;
            else              op = 6'(int'($urandom_range(22, 62)));
            r = $urandom;
            insn = {op, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), r[15:0]};
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 4)] = ($urandom_range(0, 1) == 0) ? 32'd5 : $urandom;
            ex_en        = 1'($urandom_range(0, 1));
            ex_gpr_we_   = ($urandom_range(0, 2) == 0);
            ex_dst_addr  = 5'($urandom_range(0, 4));
            ex_fwd_data  = $urandom;
            mem_en       = 1'($urandom_range(0, 1));
            mem_gpr_we_  = ($urandom_range(0, 2) == 0);
            mem_dst_addr = 5'($urandom_range(0, 4));
            mem_fwd_data = ($urandom_range(0, 1) == 0) ? 32'd5 : $urandom;
            r = $urandom;
            apply(insn, r[29:0], ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            clock_in();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
